// File: rtl/noise_conditioner_pkg.sv
// Shared types and constants for the noise conditioner: extractor states,
// default LFSR taps/seed and the pool-count width helper.
package noise_pkg;

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int count_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/noise_conditioner_if.sv
// Random-bit delivery bundle between the noise conditioner (master) and its
// consumer (slave): valid/ready handshake plus state and health observability.
interface noise_conditioner_if #(
    parameter int WIDTH = 16
);
    localparam int CW = noise_pkg::count_w(WIDTH);

    logic             rand_ready;
    logic             rand_valid;
    logic             rand_bit;
    logic [WIDTH-1:0] rand_word;
    logic [CW-1:0]    pool_count;
    logic             entropy_ok;

    modport master (
        input  rand_ready,
        output rand_valid, rand_bit, rand_word, pool_count, entropy_ok
    );

    modport slave (
        output rand_ready,
        input  rand_valid, rand_bit, rand_word, pool_count, entropy_ok
    );
endinterface

// File: rtl/noise_conditioner_bit_synchronizer.sv
// Multi-flop synchroniser that brings an asynchronous level into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    // Shift chain; the last stage is the metastability-settled output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/noise_conditioner.sv
// Noise conditioner: synchronise, von Neumann de-bias, mix into a Galois LFSR,
// serve bits via valid/ready. Define NOISE_HEALTH_EN for the stuck-source monitor.
module noise_conditioner
    import noise_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] POLY        = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] SEED        = DEFAULT_SEED,
    parameter int               SYNC_STAGES = 2,
    parameter int               STUCK_LIMIT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clkDiv,
    input  logic                noise,
    noise_conditioner_if.master rng
);
    localparam int CW = count_w(WIDTH);

    logic             w_ns;
    vn_state_t        r_state, w_state_next;
    logic             r_a, w_a_next;
    logic             r_vn_valid, w_vn_valid_next;
    logic             r_vn_bit, w_vn_bit_next;
    logic             r_ok;
    logic             w_inject;
    logic [WIDTH-1:0] r_lfsr, w_lfsr_step, w_lfsr_next;
    logic [CW-1:0]    r_pool, w_pool_next;
    logic             w_valid, w_hs;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .i_d   (noise),
        .o_q   (w_ns)
    );

    // Von Neumann extractor next-state; only sample-enable cycles advance it.
    always_comb begin
        w_state_next    = r_state;
        w_a_next        = r_a;
        w_vn_valid_next = 1'b0;
        w_vn_bit_next   = r_vn_bit;
        if (clkDiv) begin
            case (r_state)
                VN_FIRST: begin
                    w_a_next     = w_ns;
                    w_state_next = VN_SECOND;
                end
                VN_SECOND: begin
                    if (r_a != w_ns) begin
                        w_vn_valid_next = 1'b1;
                        w_vn_bit_next   = r_a;
                    end else begin
                        w_vn_valid_next = 1'b0;
                    end
                    w_state_next = VN_FIRST;
                end
                default: w_state_next = VN_FIRST;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Extractor state and its registered one-cycle output strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= VN_FIRST;
            r_a        <= 1'b0;
            r_vn_valid <= 1'b0;
            r_vn_bit   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_a        <= w_a_next;
            r_vn_valid <= w_vn_valid_next;
            r_vn_bit   <= w_vn_bit_next;
        end
    end

`ifdef NOISE_HEALTH_EN
    localparam int RW = $clog2(STUCK_LIMIT + 1);
    logic          r_prev;
    logic [RW-1:0] r_rep, w_rep_next;

    // Repetition count saturates at the limit so a long stuck run cannot wrap.
    always_comb begin
        if (w_ns == r_prev) begin
            w_rep_next = (r_rep == RW'(STUCK_LIMIT)) ? r_rep : r_rep + RW'(1);
        end else begin
            w_rep_next = {RW{1'b0}};
        end
    end

    // Health starts bad and only a differing sample can clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
            r_rep  <= {RW{1'b0}};
            r_ok   <= 1'b0;
        end else if (clkDiv) begin
            r_prev <= w_ns;
            r_rep  <= w_rep_next;
            if (w_ns != r_prev) begin
                r_ok <= 1'b1;
            end else if (w_rep_next >= RW'(STUCK_LIMIT)) begin
                r_ok <= 1'b0;
            end
        end
    end

    assign w_inject = r_vn_valid & r_ok;
`else
    // Without the monitor the source is reported healthy once out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ok <= 1'b0;
        end else begin
            r_ok <= 1'b1;
        end
    end

    assign w_inject = r_vn_valid;
`endif

    assign w_valid = (r_pool != {CW{1'b0}});
    assign w_hs    = w_valid & rng.rand_ready;

    // One Galois step, optional top-bit injection, lock-up guard back to SEED.
    always_comb begin
        w_lfsr_step = {1'b0, r_lfsr[WIDTH-1:1]}
                    ^ (r_lfsr[0] ? POLY : {WIDTH{1'b0}})
                    ^ {w_inject & r_vn_bit, {(WIDTH-1){1'b0}}};
        if (w_lfsr_step == {WIDTH{1'b0}}) begin
            w_lfsr_next = SEED;
        end else begin
            w_lfsr_next = w_lfsr_step;
        end
    end

    // Pool accounting: injection and handshake in one cycle cancel out.
    always_comb begin
        case ({w_inject, w_hs})
            2'b10:   w_pool_next = (r_pool == CW'(WIDTH)) ? r_pool : r_pool + CW'(1);
            2'b01:   w_pool_next = r_pool - CW'(1);
            default: w_pool_next = r_pool;
        endcase
    end

    // LFSR and pool state; a coincident injection and handshake is one step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
            r_pool <= {CW{1'b0}};
        end else begin
            if (w_inject || w_hs) begin
                r_lfsr <= w_lfsr_next;
            end
            r_pool <= w_pool_next;
        end
    end

    assign rng.rand_valid = w_valid;
    assign rng.rand_bit   = r_lfsr[0];
    assign rng.rand_word  = r_lfsr;
    assign rng.pool_count = r_pool;
    assign rng.entropy_ok = r_ok;
endmodule

// File: tb/tb_noise_conditioner.sv
// Self-checking bench for noise_conditioner against a pair-level reference model.
module tb_noise_conditioner;
    localparam logic [15:0] POLY = 16'hB400;
    localparam logic [15:0] SEED = 16'h0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clkDiv = 1'b0;
    logic noise = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr = SEED;
    int m_pool = 0;

    noise_conditioner_if #(.WIDTH(16)) rng ();

    noise_conditioner dut (
        .clk    (clk),
        .rst    (rst),
        .clkDiv (clkDiv),
        .noise  (noise),
        .rng    (rng)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_step(input logic [15:0] s, input bit inj, input bit b);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ POLY;
        if (inj && b) n[15] = ~n[15];
        if (n == 16'h0000) n = SEED;
        return n;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; clkDiv = 1'b0; noise = 1'b0; rng.rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m_lfsr = SEED;
        m_pool = 0;
    endtask

    // Hold noise long enough to pass the synchroniser, then one enable tick.
    task automatic sample(input bit n);
        @(negedge clk);
        noise = n; clkDiv = 1'b0;
        repeat (3) @(negedge clk);
        clkDiv = 1'b1;
        @(negedge clk);
        clkDiv = 1'b0;
    endtask

    task automatic do_pair(input bit a, input bit b);
        sample(a);
        sample(b);
        @(negedge clk);
        if (a != b) begin
            m_lfsr = m_step(m_lfsr, 1'b1, a);
            if (m_pool < 16) m_pool++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; rng.rand_ready = 1'b0;
        #1;
        checks++; if (rng.rand_word !== SEED) begin errors++; $display("FAIL reset_word got %h exp %h", rng.rand_word, SEED); end
        checks++; if (rng.rand_bit !== SEED[0]) begin errors++; $display("FAIL reset_bit got %b exp %b", rng.rand_bit, SEED[0]); end
        checks++; if (rng.pool_count !== 5'd0) begin errors++; $display("FAIL reset_pool got %0d exp 0", rng.pool_count); end
        checks++; if (rng.rand_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rng.rand_valid); end
        checks++; if (rng.entropy_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %b exp 0", rng.entropy_ok); end
        apply_reset();
    endtask

    task automatic test_pattern();
        do_pair(1'b0, 1'b1);
        checks++; if (rng.rand_word !== 16'hB400) begin errors++; $display("FAIL pattern_word got %h exp b400", rng.rand_word); end
        checks++; if (rng.pool_count !== 5'd1) begin errors++; $display("FAIL pattern_pool got %0d exp 1", rng.pool_count); end
        checks++; if (rng.rand_valid !== 1'b1) begin errors++; $display("FAIL pattern_valid got %b exp 1", rng.rand_valid); end
        checks++; if (rng.entropy_ok !== 1'b1) begin errors++; $display("FAIL pattern_ok got %b exp 1", rng.entropy_ok); end
    endtask

    task automatic test_equal_pairs();
        apply_reset();
        do_pair(1'b0, 1'b0);
        do_pair(1'b1, 1'b1);
        checks++; if (rng.rand_word !== SEED) begin errors++; $display("FAIL equal_word got %h exp %h", rng.rand_word, SEED); end
        checks++; if (rng.pool_count !== 5'd0) begin errors++; $display("FAIL equal_pool got %0d exp 0", rng.pool_count); end
        checks++; if (rng.rand_valid !== 1'b0) begin errors++; $display("FAIL equal_valid got %b exp 0", rng.rand_valid); end
    endtask

    task automatic test_saturate_drain();
        int hs;
        bit v;
        hs = 0;
        for (int i = 0; i < 40; i++) do_pair(1'b1, 1'b0);
        checks++; if (rng.pool_count !== 5'd16) begin errors++; $display("FAIL sat_pool got %0d exp 16", rng.pool_count); end
        checks++; if (rng.rand_word !== m_lfsr) begin errors++; $display("FAIL sat_word got %h exp %h", rng.rand_word, m_lfsr); end
        rng.rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            v = rng.rand_valid;
            if (v) begin
                hs++;
                m_lfsr = m_step(m_lfsr, 1'b0, 1'b0);
                if (m_pool > 0) m_pool--;
            end
            @(negedge clk);
            checks++; if (rng.rand_word !== m_lfsr) begin errors++; $display("FAIL drain_word step %0d got %h exp %h", i, rng.rand_word, m_lfsr); end
        end
        rng.rand_ready = 1'b0;
        checks++; if (hs != 16) begin errors++; $display("FAIL drain_count got %0d exp 16", hs); end
        checks++; if (rng.rand_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", rng.rand_valid); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) do_pair(1'b1, 1'b0);
        checks++; if (rng.pool_count !== 5'd3) begin errors++; $display("FAIL simul_pre_pool got %0d exp 3", rng.pool_count); end
        sample(1'b1);
        @(negedge clk);
        noise = 1'b0; clkDiv = 1'b0;
        repeat (3) @(negedge clk);
        clkDiv = 1'b1;
        @(negedge clk);
        clkDiv = 1'b0;
        rng.rand_ready = 1'b1;
        @(negedge clk);
        rng.rand_ready = 1'b0;
        m_lfsr = m_step(m_lfsr, 1'b1, 1'b1);
        checks++; if (rng.pool_count !== 5'd3) begin errors++; $display("FAIL simul_pool got %0d exp 3", rng.pool_count); end
        checks++; if (rng.rand_word !== m_lfsr) begin errors++; $display("FAIL simul_word got %h exp %h", rng.rand_word, m_lfsr); end
    endtask

    task automatic test_random();
        bit a, b;
        for (int i = 0; i < 16; i++) begin
            a = 1'($urandom_range(1, 0));
            b = 1'($urandom_range(1, 0));
            do_pair(a, b);
            checks++; if (rng.rand_word !== m_lfsr) begin errors++; $display("FAIL rand_word pair %0d got %h exp %h", i, rng.rand_word, m_lfsr); end
            checks++; if (rng.pool_count !== 5'(m_pool)) begin errors++; $display("FAIL rand_pool pair %0d got %0d exp %0d", i, rng.pool_count, m_pool); end
            checks++; if (rng.rand_bit !== m_lfsr[0]) begin errors++; $display("FAIL rand_bit pair %0d got %b exp %b", i, rng.rand_bit, m_lfsr[0]); end
        end
    endtask

`ifdef NOISE_HEALTH_EN
    task automatic test_health();
        int p0;
        do_pair(1'b0, 1'b1);
        p0 = m_pool;
        for (int i = 0; i < 15; i++) do_pair(1'b1, 1'b1);
        checks++; if (rng.entropy_ok !== 1'b1) begin errors++; $display("FAIL health_before got %b exp 1", rng.entropy_ok); end
        do_pair(1'b1, 1'b1);
        checks++; if (rng.entropy_ok !== 1'b0) begin errors++; $display("FAIL health_stuck got %b exp 0", rng.entropy_ok); end
        for (int i = 0; i < 4; i++) do_pair(1'b1, 1'b1);
        checks++; if (rng.pool_count !== 5'(p0)) begin errors++; $display("FAIL health_pool got %0d exp %0d", rng.pool_count, p0); end
        do_pair(1'b1, 1'b0);
        checks++; if (rng.entropy_ok !== 1'b1) begin errors++; $display("FAIL health_recover got %b exp 1", rng.entropy_ok); end
        checks++; if (rng.rand_word !== m_lfsr) begin errors++; $display("FAIL health_word got %h exp %h", rng.rand_word, m_lfsr); end
    endtask
`endif

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) do_pair(1'b1, 1'b0);
        checks++; if (rng.pool_count !== 5'd5) begin errors++; $display("FAIL mid_pre_pool got %0d exp 5", rng.pool_count); end
        sample(1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rng.rand_word !== SEED) begin errors++; $display("FAIL mid_word got %h exp %h", rng.rand_word, SEED); end
        checks++; if (rng.pool_count !== 5'd0) begin errors++; $display("FAIL mid_pool got %0d exp 0", rng.pool_count); end
        checks++; if (rng.rand_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", rng.rand_valid); end
        checks++; if (rng.entropy_ok !== 1'b0) begin errors++; $display("FAIL mid_ok got %b exp 0", rng.entropy_ok); end
        @(negedge clk);
        rst = 1'b1;
        m_lfsr = SEED;
        m_pool = 0;
        do_pair(1'b0, 1'b1);
        checks++; if (rng.rand_word !== 16'hB400) begin errors++; $display("FAIL mid_after_word got %h exp b400", rng.rand_word); end
        checks++; if (rng.pool_count !== 5'd1) begin errors++; $display("FAIL mid_after_pool got %0d exp 1", rng.pool_count); end
    endtask

    initial begin
        rng.rand_ready = 1'b0;
        test_reset();
        test_pattern();
        test_equal_pairs();
        test_saturate_drain();
        test_simultaneous();
        test_random();
`ifdef NOISE_HEALTH_EN
        test_health();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
